// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end and the control decoder.
package instr_fetch_unit_pkg;

   localparam int unsigned DEFAULT_ADDR_W   = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_BR_EQ  = 6'b010101;
   localparam logic [5:0] OP_BR_NEQ = 6'b010100;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b001111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   function automatic logic [5:0] get_opcode(input logic [31:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of memory handshake, redirect and decode-side signals of the fetch unit.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic              instr_valid;
   logic [31:0]       instr;
   logic [5:0]        opcode;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_plus4;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4,
      input  imem_ack, imem_rdata, stall, branch_taken, branch_target, jump, jump_target
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4,
      output imem_ack, imem_rdata, stall, branch_taken, branch_target, jump, jump_target
   );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: jump over branch over sequential, redirect targets word aligned.
module pc_next_sel #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] next_pc,
   output logic              redirect
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   // Priority mux; the sequential path wraps naturally at the address width.
   always_comb begin
      redirect = jump | branch_taken;
      if (jump) begin
         next_pc = jump_target & ALIGN_MASK;
      end else if (branch_taken) begin
         next_pc = branch_target & ALIGN_MASK;
      end else begin
         next_pc = pc + ADDR_W'(4);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over req/ack and holds each
// instruction until the downstream stage takes it.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input logic               clk,
   input logic               rst_n,
   instr_fetch_unit_if.master bus
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_pending_q, pc_pending_d;
   logic              kill_q, kill_d;
   logic              drop_q, drop_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
   logic              valid_q, valid_d;
   logic              imem_req_c;
   logic [ADDR_W-1:0] next_pc;
   logic              redirect;

   pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
      .pc            (pc_q),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .next_pc       (next_pc),
      .redirect      (redirect)
   );

   // Fetch sequencing; a redirect during an open handshake is deferred via kill/pending.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_pending_d = pc_pending_q;
      kill_d       = kill_q;
      drop_d       = 1'b0;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      pc_plus4_d   = pc_plus4_q;
      valid_d      = valid_q;
      imem_req_c   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (drop_q) begin
               if (redirect) begin
                  pc_d = next_pc;
               end
            end else begin
               imem_req_c = 1'b1;
               if (bus.imem_ack) begin
                  if (kill_q) begin
                     kill_d = 1'b0;
                     pc_d   = redirect ? next_pc : pc_pending_q;
                  end else if (redirect) begin
                     pc_d   = next_pc;
                     drop_d = 1'b1;
                  end else begin
                     instr_d    = bus.imem_rdata;
                     pc_out_d   = pc_q;
                     pc_plus4_d = pc_q + ADDR_W'(4);
                     valid_d    = 1'b1;
                     state_d    = ST_HOLD;
                  end
               end else if (redirect) begin
                  kill_d       = 1'b1;
                  pc_pending_d = next_pc;
               end
            end
         end
         ST_HOLD: begin
            if (redirect || !bus.stall) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         pc_pending_q <= RESET_PC;
         kill_q       <= 1'b0;
         drop_q       <= 1'b0;
         instr_q      <= 32'h0;
         pc_out_q     <= RESET_PC;
         pc_plus4_q   <= RESET_PC + ADDR_W'(4);
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_pending_q <= pc_pending_d;
         kill_q       <= kill_d;
         drop_q       <= drop_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         pc_plus4_q   <= pc_plus4_d;
         valid_q      <= valid_d;
      end
   end

   assign bus.imem_req    = imem_req_c;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.opcode      = get_opcode(instr_q);
   assign bus.pc_out      = pc_out_q;
   assign bus.pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a simple delayed-ack memory model.
module tb_instr_fetch_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   memDelay;
   int   waitCnt;

   instr_fetch_unit_if #(.ADDR_W(32)) bus ();

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memData(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h2008_0005;
      return 32'h8C00_0000 | addr;
   endfunction

   // Memory model: acks after memDelay request cycles, drives at negedge.
   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      waitCnt        = 0;
      forever begin
         @(negedge clk);
         if (bus.imem_req) begin
            if (waitCnt == memDelay) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = memData(bus.imem_addr);
               waitCnt        = 0;
            end else begin
               bus.imem_ack = 1'b0;
               waitCnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            waitCnt      = 0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic jmp, input logic [31:0] jt,
                                input logic br, input logic [31:0] bt);
      bus.stall         = st;
      bus.jump          = jmp;
      bus.jump_target   = jt;
      bus.branch_taken  = br;
      bus.branch_target = bt;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic checkHeld(input string tag, input logic [31:0] word, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
      checkOutput({tag, "_instr"}, bus.instr, word);
      checkOutput({tag, "_opcode"}, 32'(bus.opcode), 32'(word[31:26]));
      checkOutput({tag, "_pc"}, bus.pc_out, pc);
      checkOutput({tag, "_pc4"}, bus.pc_plus4, pc + 32'd4);
   endtask

   task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
      checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'(req));
      checkOutput({tag, "_addr"}, bus.imem_addr, addr);
   endtask

   task automatic checkReset(input string tag);
      checkReq(tag, 1'b0, 32'h0);
      checkOutput({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
      checkOutput({tag, "_instr"}, bus.instr, 32'h0);
      checkOutput({tag, "_opcode"}, 32'(bus.opcode), 32'h0);
      checkOutput({tag, "_pc"}, bus.pc_out, 32'h0);
      checkOutput({tag, "_pc4"}, bus.pc_plus4, 32'h4);
   endtask

   // Directed sequence; every step lands on a negedge, one cycle per nextCycle().
   initial begin
      checks   = 0;
      failures = 0;
      memDelay = 0;
      rst_n    = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;

      // Zero-wait fetch of addr 0.
      nextCycle();
      checkReq("c1", 1'b1, 32'h0);
      checkOutput("c1_valid", 32'(bus.instr_valid), 32'd0);
      nextCycle();
      checkHeld("c2", 32'h2008_0005, 32'h0);
      checkOutput("c2_addi", 32'(bus.opcode), 32'(6'b001000));
      checkOutput("c2_noreq", 32'(bus.imem_req), 32'd0);
      memDelay = 3;

      // Three-cycle ack delay on addr 4.
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         checkReq("wait", 1'b1, 32'h4);
         checkOutput("wait_valid", 32'(bus.instr_valid), 32'd0);
      end
      nextCycle();
      checkHeld("ack3", 32'h8C00_0004, 32'h4);
      memDelay = 0;
      bus.stall = 1'b1;

      // Stall five cycles in HOLD.
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkHeld("stall", 32'h8C00_0004, 32'h4);
         checkOutput("stall_noreq", 32'(bus.imem_req), 32'd0);
      end
      bus.stall = 1'b0;
      nextCycle();
      checkReq("unstall", 1'b1, 32'h8);
      nextCycle();
      checkHeld("f8", 32'h8C00_0008, 32'h8);

      // Jump while stalled in HOLD drops the held instruction.
      applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("jmp_valid", 32'(bus.instr_valid), 32'd0);
      checkReq("jmp", 1'b1, 32'h100);
      nextCycle();
      checkHeld("f100", 32'h8C00_0100, 32'h100);
      memDelay = 2;

      // Branch during a pending request: old data must be discarded.
      nextCycle();
      checkReq("pend", 1'b1, 32'h104);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkReq("kill1", 1'b1, 32'h104);
      nextCycle();
      checkReq("kill2", 1'b1, 32'h104);
      nextCycle();
      checkReq("reissue", 1'b1, 32'h40);
      checkOutput("kill_valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("kill_instr", bus.instr, 32'h8C00_0100);
      nextCycle();
      nextCycle();
      nextCycle();
      checkHeld("f40", 32'h8C00_0040, 32'h40);
      memDelay = 0;

      // Jump and branch together: jump wins.
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkReq("prio", 1'b1, 32'h200);
      nextCycle();
      checkHeld("f200", 32'h8C00_0200, 32'h200);

      // Wrap of the sequential PC at the top of the address space.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkReq("top", 1'b1, 32'hFFFF_FFFC);
      nextCycle();
      checkOutput("top_pc", bus.pc_out, 32'hFFFF_FFFC);
      checkOutput("top_pc4", bus.pc_plus4, 32'h0);
      nextCycle();
      checkReq("wrap", 1'b1, 32'h0);
      nextCycle();
      checkHeld("f0", 32'h2008_0005, 32'h0);

      // Branch coincident with ack: data dropped, request low for one cycle.
      nextCycle();
      checkReq("co", 1'b1, 32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkReq("co_drop", 1'b0, 32'h80);
      checkOutput("co_valid", 32'(bus.instr_valid), 32'd0);
      nextCycle();
      checkReq("co_reissue", 1'b1, 32'h80);
      nextCycle();
      checkHeld("f80", 32'h8C00_0080, 32'h80);
      memDelay = 5;

      // Reset in the middle of a request.
      nextCycle();
      checkReq("mid", 1'b1, 32'h84);
      rst_n = 1'b0;
      nextCycle();
      checkReset("midrst");
      memDelay = 0;
      rst_n = 1'b1;
      nextCycle();
      checkReq("restart", 1'b1, 32'h0);
      nextCycle();
      checkHeld("restart", 32'h2008_0005, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
